branch_resolve: RTL

- Consumes the equal/not_equal flags from the operand equality comparator in the decode stage, together with the decoded branch type and the precomputed target.
- Decides whether a BEQ/BNE is taken and issues a registered PC redirect to fetch.
- Drives a multi-cycle IF flush and holds a busy window during which new branches are ignored.
- Keeps saturating taken/resolved statistics counters for the performance-counter block.

---
 rtl/branch_resolve_if.sv | 34 +++
 rtl/branch_resolve.sv | 107 ++++++++++
 2 files changed

// File: rtl/branch_resolve_if.sv
// Decode-to-fetch branch bus. The decode side drives the branch, comparator and stall signals.
// The resolver drives the redirect, flush and statistics signals.
interface branch_resolve_if #(
    parameter int ADDR_BITS = 32,
    parameter int CNT_BITS  = 16
);
    logic                 br_valid;
    logic                 br_beq;
    logic                 br_bne;
    logic                 equal;
    logic                 not_equal;
    logic [ADDR_BITS-1:0] br_target;
    logic                 stall_in;

    logic                 redirect_valid;
    logic [ADDR_BITS-1:0] redirect_pc;
    logic                 flush_if;
    logic                 busy;
    logic                 illegal_pulse;
    logic [CNT_BITS-1:0]  taken_count;
    logic [CNT_BITS-1:0]  resolved_count;

    modport master (
        output br_valid, br_beq, br_bne, equal, not_equal, br_target, stall_in,
        input  redirect_valid, redirect_pc, flush_if, busy, illegal_pulse,
               taken_count, resolved_count
    );

    modport slave (
        input  br_valid, br_beq, br_bne, equal, not_equal, br_target, stall_in,
        output redirect_valid, redirect_pc, flush_if, busy, illegal_pulse,
               taken_count, resolved_count
    );
endinterface

// File: rtl/branch_resolve.sv
// Resolves BEQ/BNE in decode and issues a registered PC redirect to fetch.
// Holds an IF flush window and keeps saturating taken/resolved statistics.
module branch_resolve #(
    parameter int ADDR_BITS    = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_BITS     = 16
) (
    input logic             clk,
    input logic             rst,
    branch_resolve_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam logic [3:0]          FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1);

    state_e               state_q, state_d;
    logic [3:0]           flush_cnt_q, flush_cnt_d;
    logic                 redirect_valid_q;
    logic                 illegal_q;
    logic [ADDR_BITS-1:0] redirect_pc_q;
    logic [CNT_BITS-1:0]  taken_cnt_q;
    logic [CNT_BITS-1:0]  resolved_cnt_q;

    logic resolve;
    logic taken;
    logic illegal;

    // Branches arriving in FLUSH, including the last cycle, are squashed by fetch.
    assign resolve = bus.br_valid & ~bus.stall_in & (state_q == IDLE);
    assign taken   = resolve & ((bus.br_beq & ~bus.br_bne & bus.equal) |
                                (bus.br_bne & ~bus.br_beq & bus.not_equal));
    assign illegal = resolve & bus.br_beq & bus.br_bne;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (taken) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.flush_if = (state_q == FLUSH);
        bus.busy     = (state_q == FLUSH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            illegal_q        <= 1'b0;
            redirect_pc_q    <= '0;
            taken_cnt_q      <= '0;
            resolved_cnt_q   <= '0;
        end else begin
            redirect_valid_q <= taken;
            illegal_q        <= illegal;
            if (taken) begin
                redirect_pc_q <= bus.br_target;
            end
            if (taken && taken_cnt_q != CNT_MAX) begin
                taken_cnt_q <= taken_cnt_q + CNT_ONE;
            end
            if (resolve && resolved_cnt_q != CNT_MAX) begin
                resolved_cnt_q <= resolved_cnt_q + CNT_ONE;
            end
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.illegal_pulse  = illegal_q;
    assign bus.taken_count    = taken_cnt_q;
    assign bus.resolved_count = resolved_cnt_q;

endmodule
